// File: rtl/prbs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_pkg                                                                 |
// | Shared definitions for the PRBS generator/checker pair: checker state    |
// | type and the per-length feedback tap masks, so both ends always use the  |
// | same polynomial.                                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Bit j set means history bit h[j] (received j+1 bits ago) feeds the XOR.
  localparam logic [31:0] c_taps_n4  = 32'h0000_000C;  // {3,2}
  localparam logic [31:0] c_taps_n8  = 32'h0000_00B4;  // {7,5,4,2}
  localparam logic [31:0] c_taps_n16 = 32'h0000_8842;  // {15,11,6,1}
  localparam logic [31:0] c_taps_n32 = 32'h8020_0003;  // {31,21,1,0}

  function automatic bit legal_len(input int unsigned n);
    return (n == 4) || (n == 8) || (n == 16) || (n == 32);
  endfunction

  function automatic logic [31:0] tap_mask(input int unsigned n);
    case (n)
      4:       return c_taps_n4;
      8:       return c_taps_n8;
      16:      return c_taps_n16;
      32:      return c_taps_n32;
      default: return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_if                                                                  |
// | Serial bit stream in, lock status and counters out.                      |
// |   master: drives clr, bit_in, bit_vld; observes status/counters          |
// |   slave : the checker side                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface prbs_if #(
  parameter int CW = 16
);
  logic          clr;
  logic          bit_in;
  logic          bit_vld;
  logic          locked;
  logic          err_pulse;
  logic          sync_loss;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] err_cnt;

  modport master (
    output clr, bit_in, bit_vld,
    input  locked, err_pulse, sync_loss, bit_cnt, err_cnt
  );

  modport slave (
    input  clr, bit_in, bit_vld,
    output locked, err_pulse, sync_loss, bit_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prbs_tap_xor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_tap_xor                                                             |
// | Combinational next-bit prediction: XOR of the history taps for length N. |
// |   h_i    : history, h_i[j] = bit received j+1 valid bits ago             |
// |   pred_o : predicted next bit                                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prbs_tap_xor
  import prbs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] h_i,
  output logic         pred_o
);

  localparam logic [N-1:0] c_mask = N'(tap_mask(N));

  assign pred_o = ^(h_i & c_mask);

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_checker                                                             |
// | Self-synchronizing serial PRBS checker. Fills its history from the       |
// | stream, verifies LOCK_CNT consecutive predictions, then counts checked   |
// | bits and errors while locked; drops lock when ERR_LIM errors land in one |
// | ERR_WIN-bit window.                                                      |
// |   clk, rst_n (async, active-low)                                         |
// |   bus.clr/bit_in/bit_vld          : inputs                               |
// |   bus.locked/err_pulse/sync_loss  : registered status                    |
// |   bus.bit_cnt/err_cnt             : saturating counters                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 8,
  parameter int ERR_WIN  = 64,
  parameter int ERR_LIM  = 4,
  parameter int CW       = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  prbs_if.slave bus
);

  localparam int c_fw = $clog2(N);
  localparam int c_mw = $clog2(LOCK_CNT + 1);
  localparam int c_ww = $clog2(ERR_WIN + 1);
  localparam int c_ew = $clog2(ERR_LIM + 1);

  if (!legal_len(N)) begin : g_bad_len
    $fatal(1, "prbs_checker: N=%0d is not one of 4, 8, 16, 32", N);
  end

  prbs_state_e     state_q;
  logic [N-1:0]    h_q;
  logic [N-1:0]    h_d;
  logic [c_fw-1:0] fcnt_q;
  logic [c_mw-1:0] mcnt_q;
  logic [c_mw-1:0] mcnt_d;
  logic [c_ww-1:0] wcnt_q;
  logic [c_ww-1:0] wcnt_d;
  logic [c_ew-1:0] werr_q;
  logic [c_ew-1:0] werr_d;
  logic [CW-1:0]   bit_cnt_q;
  logic [CW-1:0]   bit_cnt_d;
  logic [CW-1:0]   err_cnt_q;
  logic [CW-1:0]   err_cnt_d;
  logic            locked_q;
  logic            err_pulse_q;
  logic            sync_loss_q;

  logic pred;
  logic mismatch;
  logic h_zero;
  logic fill_done;
  logic lock_hit;
  logic lim_hit;
  logic win_end;

  prbs_tap_xor #(.N(N)) u_tap_xor (
    .h_i    (h_q),
    .pred_o (pred)
  );

  always_comb begin
    // Once locked, the history follows the prediction rather than the line,
    // so a single corrupted bit cannot propagate into later predictions.
    h_d       = {h_q[N-2:0], (state_q == LOCKED) ? pred : bus.bit_in};
    mismatch  = bus.bit_in ^ pred;
    h_zero    = ~|h_q;
    mcnt_d    = mcnt_q + c_mw'(1);
    wcnt_d    = wcnt_q + c_ww'(1);
    werr_d    = werr_q + c_ew'(1);
    fill_done = (fcnt_q == c_fw'(N - 1));
    lock_hit  = (mcnt_d == c_mw'(LOCK_CNT));
    lim_hit   = mismatch && (werr_d == c_ew'(ERR_LIM));
    win_end   = (wcnt_d == c_ww'(ERR_WIN));
    bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CW'(1);
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      h_q         <= '0;
      fcnt_q      <= '0;
      mcnt_q      <= '0;
      wcnt_q      <= '0;
      werr_q      <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      if (bus.bit_vld) begin
        h_q <= h_d;
        unique case (state_q)
          FILL: begin
            if (fill_done) begin
              state_q <= VERIFY;
              fcnt_q  <= '0;
              mcnt_q  <= '0;
            end else begin
              fcnt_q  <= fcnt_q + c_fw'(1);
            end
          end
          VERIFY: begin
            // An all-zero history predicts 0 forever; never count it as a match.
            if (h_zero || mismatch) begin
              mcnt_q <= '0;
            end else if (lock_hit) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              mcnt_q   <= '0;
              wcnt_q   <= '0;
              werr_q   <= '0;
            end else begin
              mcnt_q <= mcnt_d;
            end
          end
          LOCKED: begin
            bit_cnt_q <= bit_cnt_d;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
            end
            // Error limit is judged before the window wraps on the same bit.
            if (lim_hit) begin
              state_q     <= FILL;
              fcnt_q      <= '0;
              locked_q    <= 1'b0;
              sync_loss_q <= 1'b1;
            end else if (win_end) begin
              wcnt_q <= '0;
              werr_q <= '0;
            end else begin
              wcnt_q <= wcnt_d;
              if (mismatch) begin
                werr_q <= werr_d;
              end
            end
          end
          default: state_q <= FILL;
        endcase
      end
      // Clear overrides any same-cycle increment.
      if (bus.clr) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_loss = sync_loss_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prbs_checker                                                          |
// | Bench for prbs_checker: segment table plus randomized stream against a   |
// | behavioural reference, and lock runs for N = 8, 16, 32.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_prbs_checker;

  localparam int LOCK_CNT = 8;
  localparam int ERR_WIN  = 64;
  localparam int ERR_LIM  = 4;
  localparam int CW       = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_if #(.CW(CW)) if4  ();
  prbs_if #(.CW(CW)) if8  ();
  prbs_if #(.CW(CW)) if16 ();
  prbs_if #(.CW(CW)) if32 ();

  prbs_checker #(.N(4), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_LIM(ERR_LIM), .CW(CW))
    u_n4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  prbs_checker #(.N(8), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_LIM(ERR_LIM), .CW(CW))
    u_n8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  prbs_checker #(.N(16), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_LIM(ERR_LIM), .CW(CW))
    u_n16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  prbs_checker #(.N(32), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_LIM(ERR_LIM), .CW(CW))
    u_n32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- pattern generators (one per length) ----------------
  int gen_len [4]    = '{4, 8, 16, 32};
  int tap_tbl [4][4] = '{'{3, 2, -1, -1}, '{7, 5, 4, 2}, '{15, 11, 6, 1}, '{31, 21, 1, 0}};
  bit gh      [4][32];
  int gcount  [4];

  task automatic gen_reset();
    for (int i = 0; i < 4; i++) begin
      gcount[i] = 0;
      for (int j = 0; j < 32; j++) gh[i][j] = 1'b0;
    end
  endtask

  // First N outputs are the seed 0..01, then x[n] = XOR of x[n-1-t] over taps t.
  task automatic gen_next(input int i, output bit b);
    if (gcount[i] < gen_len[i]) begin
      b = (gcount[i] == gen_len[i] - 1);
    end else begin
      b = 1'b0;
      for (int t = 0; t < 4; t++)
        if (tap_tbl[i][t] >= 0) b ^= gh[i][tap_tbl[i][t]];
    end
    for (int j = 31; j > 0; j--) gh[i][j] = gh[i][j-1];
    gh[i][0] = b;
    gcount[i]++;
  endtask

  // ---------------- reference model for the N=4 checker ----------------
  int     m_hist[$];  // reconstructed history, newest first
  int     m_need;     // bits still needed before predictions are judged
  int     m_run;      // consecutive correct predictions
  bit     m_lock;
  int     m_wpos;
  int     m_werr;
  longint m_bcnt;
  longint m_ecnt;
  bit     e_err;
  bit     e_loss;

  task automatic model_reset();
    m_hist = '{0, 0, 0, 0};
    m_need = 4;
    m_run  = 0;
    m_lock = 1'b0;
    m_wpos = 0;
    m_werr = 0;
    m_bcnt = 0;
    m_ecnt = 0;
    e_err  = 1'b0;
    e_loss = 1'b0;
  endtask

  task automatic model_step(input bit vld, input bit b, input bit clr);
    int p;
    int ones;
    e_err  = 1'b0;
    e_loss = 1'b0;
    if (vld) begin
      p    = m_hist[3] ^ m_hist[2];
      ones = 0;
      foreach (m_hist[j]) ones += m_hist[j];
      if (m_lock) begin
        if (m_bcnt < CMAX) m_bcnt++;
        m_wpos++;
        if (int'(b) != p) begin
          e_err = 1'b1;
          if (m_ecnt < CMAX) m_ecnt++;
          m_werr++;
        end
        m_hist.push_front(p);
        void'(m_hist.pop_back());
        if (m_werr == ERR_LIM) begin
          m_lock = 1'b0;
          e_loss = 1'b1;
          m_need = 4;
          m_run  = 0;
        end else if (m_wpos == ERR_WIN) begin
          m_wpos = 0;
          m_werr = 0;
        end
      end else begin
        if (m_need > 0) m_need--;
        else if (ones != 0 && int'(b) == p) m_run++;
        else m_run = 0;
        m_hist.push_front(int'(b));
        void'(m_hist.pop_back());
        if (m_run == LOCK_CNT) begin
          m_lock = 1'b1;
          m_run  = 0;
          m_wpos = 0;
          m_werr = 0;
        end
      end
    end
    if (clr) begin
      m_bcnt = 0;
      m_ecnt = 0;
    end
  endtask

  int seg_pulses;
  int seg_losses;

  task automatic idle_all();
    if4.bit_vld  = 1'b0; if4.bit_in  = 1'b0; if4.clr  = 1'b0;
    if8.bit_vld  = 1'b0; if8.bit_in  = 1'b0; if8.clr  = 1'b0;
    if16.bit_vld = 1'b0; if16.bit_in = 1'b0; if16.clr = 1'b0;
    if32.bit_vld = 1'b0; if32.bit_in = 1'b0; if32.clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    gen_reset();
  endtask

  // One clock on the N=4 checker, compared against the model after the edge.
  task automatic step4(input bit vld, input bit b, input bit clr);
    if4.bit_vld = vld;
    if4.bit_in  = b;
    if4.clr     = clr;
    @(posedge clk);
    model_step(vld, b, clr);
    #1;
    check("locked",    if4.locked,    m_lock);
    check("err_pulse", if4.err_pulse, e_err);
    check("sync_loss", if4.sync_loss, e_loss);
    check("bit_cnt",   if4.bit_cnt,   m_bcnt);
    check("err_cnt",   if4.err_cnt,   m_ecnt);
    seg_pulses += int'(if4.err_pulse);
    seg_losses += int'(if4.sync_loss);
  endtask

  // ---------------- segment table ----------------
  typedef struct {
    bit rst;       // reset before the segment
    int src;       // 0 generator, 1 all-zero, 2 all-one
    int nbits;     // valid bits in the segment
    bit gappy;     // random idle cycles between valid bits
    int first;     // first inverted bit offset
    int gap;       // spacing of inverted bits
    int nflip;     // number of inverted bits
    bit clr_last;  // clr together with the last valid bit
    bit x_lock;
    int x_bcnt;
    int x_ecnt;
    int x_pulses;
    int x_losses;
  } seg_t;

  seg_t  segs[$];
  string names[$];

  task automatic add(input string nm, input bit rst, input int src, input int nbits,
                     input bit gappy, input int first, input int gap, input int nflip,
                     input bit clr_last, input bit x_lock, input int x_bcnt,
                     input int x_ecnt, input int x_pulses, input int x_losses);
    seg_t s;
    s.rst = rst; s.src = src; s.nbits = nbits; s.gappy = gappy;
    s.first = first; s.gap = gap; s.nflip = nflip; s.clr_last = clr_last;
    s.x_lock = x_lock; s.x_bcnt = x_bcnt; s.x_ecnt = x_ecnt;
    s.x_pulses = x_pulses; s.x_losses = x_losses;
    segs.push_back(s);
    names.push_back(nm);
  endtask

  task automatic run_seg(input seg_t s, input string nm);
    int k;
    bit b;
    bit flip;
    if (s.rst) do_reset();
    seg_pulses = 0;
    seg_losses = 0;
    k = 0;
    while (k < s.nbits) begin
      if (s.gappy && $urandom_range(1, 0) == 0) begin
        step4(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      end else begin
        if (s.src == 0) gen_next(0, b);
        else b = (s.src == 2);
        flip = (s.nflip > 0) && (k >= s.first) && ((k - s.first) % s.gap == 0)
               && ((k - s.first) / s.gap < s.nflip);
        step4(1'b1, b ^ flip, s.clr_last && (k == s.nbits - 1));
        k++;
      end
    end
    check({nm, ".locked"},  if4.locked,  s.x_lock);
    check({nm, ".bit_cnt"}, if4.bit_cnt, s.x_bcnt);
    check({nm, ".err_cnt"}, if4.err_cnt, s.x_ecnt);
    check({nm, ".pulses"},  seg_pulses,  s.x_pulses);
    check({nm, ".losses"},  seg_losses,  s.x_losses);
  endtask

  initial begin
    int first_lock [4];
    int pulses     [4];
    bit b8, b16, b32;

    idle_all();
    model_reset();
    gen_reset();
    do_reset();
    check("reset.locked",    if4.locked,    0);
    check("reset.err_pulse", if4.err_pulse, 0);
    check("reset.sync_loss", if4.sync_loss, 0);
    check("reset.bit_cnt",   if4.bit_cnt,   0);
    check("reset.err_cnt",   if4.err_cnt,   0);

    //   name          rst src nbits gap first gap nflip clr lock bcnt ecnt pul los
    add("zeros",       1,  1,  100,  0,  0,    1,  0,    0,  0,   0,   0,   0,  0);
    add("ones",        0,  2,  100,  0,  0,    1,  0,    0,  0,   0,   0,   0,  0);
    add("fill11",      1,  0,  11,   0,  0,    1,  0,    0,  0,   0,   0,   0,  0);
    add("lock12",      0,  0,  1,    0,  0,    1,  0,    0,  1,   0,   0,   0,  0);
    add("run150",      0,  0,  150,  0,  0,    1,  0,    0,  1,   150, 0,   0,  0);
    add("one_err",     0,  0,  31,   0,  0,    1,  1,    0,  1,   181, 1,   1,  0);
    add("pad_clr",     0,  0,  11,   0,  0,    1,  0,    1,  1,   0,   0,   0,  0);
    add("four_err",    0,  0,  16,   0,  0,    5,  4,    0,  0,   16,  4,   4,  1);
    add("refill11",    0,  0,  11,   0,  0,    1,  0,    0,  0,   16,  4,   0,  0);
    add("relock",      0,  0,  1,    0,  0,    1,  0,    0,  1,   16,  4,   0,  0);
    add("three_win",   0,  0,  192,  0,  2,    22, 9,    0,  1,   208, 13,  9,  0);
    add("gappy_err",   0,  0,  100,  1,  10,   30, 2,    0,  1,   308, 15,  2,  0);
    add("clr_vs_err",  0,  0,  1,    0,  0,    1,  1,    1,  1,   0,   0,   1,  0);
    add("g_fill11",    1,  0,  11,   1,  0,    1,  0,    0,  0,   0,   0,   0,  0);
    add("g_lock12",    0,  0,  1,    1,  0,    1,  0,    0,  1,   0,   0,   0,  0);
    add("g_run150",    0,  0,  150,  1,  0,    1,  0,    0,  1,   150, 0,   0,  0);

    for (int i = 0; i < segs.size(); i++) run_seg(segs[i], names[i]);

    // Asynchronous reset while locked and flagging an error.
    begin
      bit b;
      gen_next(0, b);
      step4(1'b1, ~b, 1'b0);
      check("pre_rst.err_pulse", if4.err_pulse, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.locked",    if4.locked,    0);
      check("async_rst.err_pulse", if4.err_pulse, 0);
      check("async_rst.sync_loss", if4.sync_loss, 0);
      check("async_rst.bit_cnt",   if4.bit_cnt,   0);
      check("async_rst.err_cnt",   if4.err_cnt,   0);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      gen_reset();
    end

    // Randomized stream: gaps, line errors and clears against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit v, b, f, cl;
      v  = ($urandom_range(3, 0) != 0);
      f  = ($urandom_range(39, 0) == 0);
      cl = ($urandom_range(199, 0) == 0);
      if (v) gen_next(0, b);
      else b = 1'($urandom_range(1, 0));
      step4(v, b ^ (v & f), cl);
    end

    // Lock runs for the longer polynomials: one inverted bit at bit 150.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      first_lock[i] = -1;
      pulses[i]     = 0;
    end
    for (int k = 1; k <= 200; k++) begin
      gen_next(1, b8);
      gen_next(2, b16);
      gen_next(3, b32);
      if8.bit_vld  = 1'b1; if8.bit_in  = b8  ^ (k == 150);
      if16.bit_vld = 1'b1; if16.bit_in = b16 ^ (k == 150);
      if32.bit_vld = 1'b1; if32.bit_in = b32 ^ (k == 150);
      @(posedge clk);
      #1;
      if (first_lock[1] < 0 && if8.locked)  first_lock[1] = k;
      if (first_lock[2] < 0 && if16.locked) first_lock[2] = k;
      if (first_lock[3] < 0 && if32.locked) first_lock[3] = k;
      pulses[1] += int'(if8.err_pulse);
      pulses[2] += int'(if16.err_pulse);
      pulses[3] += int'(if32.err_pulse);
    end
    idle_all();
    check("n8.lock_bit",   first_lock[1], 8 + LOCK_CNT);
    check("n8.locked",     if8.locked,    1);
    check("n8.bit_cnt",    if8.bit_cnt,   200 - (8 + LOCK_CNT));
    check("n8.err_cnt",    if8.err_cnt,   1);
    check("n8.pulses",     pulses[1],     1);
    check("n16.lock_bit",  first_lock[2], 16 + LOCK_CNT);
    check("n16.locked",    if16.locked,   1);
    check("n16.bit_cnt",   if16.bit_cnt,  200 - (16 + LOCK_CNT));
    check("n16.err_cnt",   if16.err_cnt,  1);
    check("n16.pulses",    pulses[2],     1);
    check("n32.lock_bit",  first_lock[3], 32 + LOCK_CNT);
    check("n32.locked",    if32.locked,   1);
    check("n32.bit_cnt",   if32.bit_cnt,  200 - (32 + LOCK_CNT));
    check("n32.err_cnt",   if32.err_cnt,  1);
    check("n32.pulses",    pulses[3],     1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial pseudo-random bit-sequence checker; the receive end of the team's LFSR pattern generator.
- Consumes the generator's 1-bit output stream and self-synchronizes to it using the same polynomial, then counts checked bits and bit errors.
- Declares and drops lock from error density.
- Sits at the sink side of the BIST/link-test path.

Parameters:
- N, 4, LFSR length; legal values 4, 8, 16, 32; any other value is an elaboration error.
- LOCK_CNT, 8, consecutive correct predictions required in VERIFY to declare lock.
- ERR_WIN, 64, error-density window length in checked bits (locked only).
- ERR_LIM, 4, errors within one window that force loss of lock.
- CW, 16, width of bit_cnt and err_cnt.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous clear of bit_cnt/err_cnt.
- bit_in  input  1  received serial bit.
- bit_vld  input  1  bit_in qualifier; all state advances only when 1.
- locked  output  1  checker is locked.
- err_pulse  output  1  one-cycle flag, last checked bit mismatched.
- sync_loss  output  1  one-cycle flag, lock dropped.
- bit_cnt  output  CW  bits checked while locked, saturating.
- err_cnt  output  CW  errors while locked, saturating.

Behaviour:
- History register h[0:N-1]: h[j] holds the bit received j+1 valid bits ago. Each valid bit shifts h by one: new bit enters h[0], old h[j] moves to h[j+1].
- Predicted bit pred is the XOR of h at the tap set:
  - N=4: {3,2}
  - N=8: {7,5,4,2}
  - N=16: {15,11,6,1}
  - N=32: {31,21,1,0}
- Reset: state FILL, h=0, fill/match/window counters 0. All outputs 0.
- FILL:
  - Each valid bit shifts bit_in into h and increments fcnt.
  - On the N-th bit, go to VERIFY with mcnt=0. No comparison is made.
- VERIFY:
  - Each valid bit compares bit_in with pred and shifts bit_in into h (self-synchronizing).
  - Match: mcnt++. Mismatch: mcnt=0.
  - If h is all-zero before the shift, mcnt is forced to 0; an all-zero stream must never lock.
  - When a match makes mcnt equal LOCK_CNT, go to LOCKED. locked=1 from the next clk edge, with window counter and window error count both 0.
- LOCKED:
  - h shifts in pred, not bit_in, so one line error yields exactly one err_pulse (no error multiplication).
  - Each valid bit: bit_cnt++ (saturate at 2^CW-1) and window counter++.
  - On mismatch: err_pulse=1 for one cycle, registered (the cycle after the sampling edge); err_cnt++ (saturating); werr++.
  - If werr reaches ERR_LIM: go to FILL with fcnt=0. On the same edge, locked drops to 0 and sync_loss pulses 1 cycle. bit_cnt/err_cnt hold their values.
  - The limit check precedes the window wrap. On the ERR_WIN-th bit, the window counter and werr return to 0 after that bit's error, if any, has been evaluated.
- err_pulse and sync_loss are 0 in every cycle without a qualifying event, including bit_vld=0 cycles.
- clr:
  - Affects bit_cnt and err_cnt only.
  - If clr coincides with an increment, clr wins and the result is 0.
  - State, lock, h and window are unaffected.
- Mid-operation rst_n assertion returns everything to reset values immediately (async); relock requires N+LOCK_CNT valid bits.
- bit_vld gaps of any length are transparent: the result is identical to a gap-free stream.

Decomposition:
- Package prbs_pkg holds:
  - state enum {FILL, VERIFY, LOCKED};
  - a tap-mask function or constants per N, shared with the generator so the two polynomials cannot diverge.
- One natural sub-module, prbs_tap_xor: combinational pred from h and N.

Test Plan:
- N=4 generator stream (seed 1000) repeating 000100110101111, bit_vld=1 continuous, LOCK_CNT=8:
  - locked rises the cycle after the 12th valid bit;
  - after 150 more bits, bit_cnt=150 and err_cnt=0.
- Locked, invert exactly one bit:
  - exactly one err_pulse;
  - err_cnt=1;
  - locked stays 1;
  - no further errors over the next 30 bits.
- Locked, invert 4 bits within a 64-bit window:
  - sync_loss pulses once on the 4th error;
  - locked=0;
  - err_cnt=4;
  - relock after 12 more clean bits.
  - Repeat with 3 errors per window over 3 windows: lock is held.
- All-zero input for 100 bits, then all-one for 100 bits:
  - locked never asserts;
  - err_cnt=0 and bit_cnt=0.
- Same stream with bit_vld toggling randomly at ~50% duty: lock timing counted in valid bits is unchanged, and counts match the gap-free run.
- While locked, assert clr on the same cycle as an error: err_cnt=0 and bit_cnt=0 afterwards. Then pulse rst_n low mid-run: all outputs 0 asynchronously. Repeat lock tests for N=8, 16, 32.
